// File: rtl/head_shift_ctrl_pkg.sv
// Shared parser-stage definitions: datapath widths, tag bit positions,
// the classification rule record and the controller state encoding.
package head_shift_ctrl_pkg;

  localparam int HEAD_WIDTH       = 512;
  localparam int TAG_WIDTH        = 8;
  localparam int META_WIDTH       = 256;
  localparam int SHIFT_WIDTH      = 16;
  localparam int HEAD_SHIFT_WIDTH = 5;
  localparam int META_SHIFT_WIDTH = 4;
  localparam int KEY_FIELD_NUM    = 4;
  localparam int RULE_NUM         = 8;

  localparam int HEAD_WORDS     = HEAD_WIDTH / SHIFT_WIDTH;
  localparam int WORD_SEL_WIDTH = $clog2(HEAD_WORDS);
  localparam int RULE_IDX_WIDTH = $clog2(RULE_NUM);
  localparam int HEAD_BUS_W     = HEAD_WIDTH + TAG_WIDTH;
  localparam int META_BUS_W     = META_WIDTH + TAG_WIDTH;
  localparam int EXT_W          = KEY_FIELD_NUM * SHIFT_WIDTH;

  // Tag bit positions, counted from the LSB of the tag that sits above the data.
  localparam int TAG_START_BIT = 0;
  localparam int TAG_VALID_BIT = 1;
  localparam int TAG_TAIL_BIT  = 2;
  localparam int TAG_SHIFT_BIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One classification rule; ext_sel[i] picks the word driven on field i.
  typedef struct packed {
    logic                                           valid;
    logic [WORD_SEL_WIDTH-1:0]                      key_sel;
    logic [SHIFT_WIDTH-1:0]                         value;
    logic [SHIFT_WIDTH-1:0]                         mask;
    logic [HEAD_SHIFT_WIDTH-1:0]                    head_shift;
    logic [META_SHIFT_WIDTH-1:0]                    meta_shift;
    logic [KEY_FIELD_NUM-1:0][WORD_SEL_WIDTH-1:0]   ext_sel;
  } rule_t;

  localparam int RULE_W = $bits(rule_t);

endpackage

// File: rtl/head_shift_ctrl_if.sv
// Bus bundle between a parser stage's head/meta stream, its config port
// and the downstream shift stage.
interface head_shift_ctrl_if;
  import head_shift_ctrl_pkg::*;

  logic [HEAD_BUS_W-1:0]       i_head;
  logic [META_BUS_W-1:0]       i_meta;
  logic [HEAD_BUS_W-1:0]       o_head;
  logic [META_BUS_W-1:0]       o_meta;
  logic [HEAD_SHIFT_WIDTH-1:0] o_headShift;
  logic [META_SHIFT_WIDTH-1:0] o_metaShift;
  logic [EXT_W-1:0]            o_extField;
  logic                        o_hit;
  logic                        o_miss;
  logic                        i_cfg_valid;
  logic [RULE_IDX_WIDTH-1:0]   i_cfg_addr;
  logic [RULE_W-1:0]           i_cfg_data;
  logic                        o_cfg_ready;
  logic [31:0]                 o_hitCnt;
  logic [31:0]                 o_missCnt;

  modport master (
    output i_head, i_meta, i_cfg_valid, i_cfg_addr, i_cfg_data,
    input  o_head, o_meta, o_headShift, o_metaShift, o_extField,
           o_hit, o_miss, o_cfg_ready, o_hitCnt, o_missCnt
  );

  modport slave (
    input  i_head, i_meta, i_cfg_valid, i_cfg_addr, i_cfg_data,
    output o_head, o_meta, o_headShift, o_metaShift, o_extField,
           o_hit, o_miss, o_cfg_ready, o_hitCnt, o_missCnt
  );

endinterface

// File: rtl/head_shift_ctrl_word_sel.sv
// Combinational word picker: returns the SHIFT_WIDTH-bit word at index sel_i,
// where word 0 is the most significant word of the head slice.
module head_word_sel
  import head_shift_ctrl_pkg::*;
(
  input  logic [HEAD_WIDTH-1:0]     data_i,
  input  logic [WORD_SEL_WIDTH-1:0] sel_i,
  output logic [SHIFT_WIDTH-1:0]    word_o
);

  logic [HEAD_WORDS-1:0][SHIFT_WIDTH-1:0] words;
  logic [WORD_SEL_WIDTH-1:0]              idx;

  // Packed index HEAD_WORDS-1 holds the MSB-most word, so flip the index.
  assign words  = data_i;
  assign idx    = WORD_SEL_WIDTH'(HEAD_WORDS - 1) - sel_i;
  assign word_o = words[idx];

endmodule

// File: rtl/head_shift_ctrl.sv
// Per-stage head/meta shift controller: classifies each packet on its first
// head slice against the rule table and presents the chosen shifts and key
// fields alongside the start slice two cycles later.
module head_shift_ctrl
  import head_shift_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  head_shift_ctrl_if.slave bus
);

  rule_t                                    rule_q [RULE_NUM];
  logic                                     in_start, in_tail;
  logic                                     cfg_ready, cfg_accept;
  state_e                                   state_q;
  logic                                     drain_q;
  logic                                     ready_q;

  logic [RULE_NUM-1:0]                      match_d, match_q;
  logic [HEAD_BUS_W-1:0]                    head_s1_q, head_s2_q;
  logic [META_BUS_W-1:0]                    meta_s1_q, meta_s2_q;
  logic                                     s1_start;

  logic                                     any_match;
  logic [RULE_IDX_WIDTH-1:0]                win_idx;
  rule_t                                    win_rule;
  logic [KEY_FIELD_NUM-1:0][SHIFT_WIDTH-1:0] ext_word;

  logic                                     hit_d, miss_d;
  logic                                     hit_q, miss_q;
  logic [HEAD_SHIFT_WIDTH-1:0]              head_shift_q;
  logic [META_SHIFT_WIDTH-1:0]              meta_shift_q;
  logic [KEY_FIELD_NUM-1:0][SHIFT_WIDTH-1:0] ext_q;
  logic [31:0]                              hit_cnt_q, miss_cnt_q;

  assign in_start = bus.i_head[HEAD_WIDTH + TAG_START_BIT];
  assign in_tail  = bus.i_head[HEAD_WIDTH + TAG_TAIL_BIT];

  // A start slice always wins over a config write offered in the same cycle.
  assign cfg_ready  = ready_q & ~in_start & ~i_rst;
  assign cfg_accept = bus.i_cfg_valid & cfg_ready;

  // Rule table: written only through the accepted config handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: only the valid bits need a reset value; the payload fields are
      // never looked at while valid is low, so they are left unreset.
      for (int r = 0; r < RULE_NUM; r++) rule_q[r].valid <= 1'b0;
    end else if (cfg_accept) begin
      rule_q[bus.i_cfg_addr] <= bus.i_cfg_data;
    end
  end

  // Stage 1 compare: one key-word picker and masked compare per rule.
  for (genvar r = 0; r < RULE_NUM; r++) begin : g_rule
    logic [SHIFT_WIDTH-1:0] key_word;

    head_word_sel u_key_sel (
      .data_i (bus.i_head[HEAD_WIDTH-1:0]),
      .sel_i  (rule_q[r].key_sel),
      .word_o (key_word)
    );

    assign match_d[r] = rule_q[r].valid &
                        ((key_word & rule_q[r].mask) == (rule_q[r].value & rule_q[r].mask));
  end

  // Stage 1 registers: slice data plus the match vector of a start slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      head_s1_q <= '0;
      meta_s1_q <= '0;
      match_q   <= '0;
    end else begin
      head_s1_q <= bus.i_head;
      meta_s1_q <= bus.i_meta;
      match_q   <= in_start ? match_d : '0;
    end
  end

  assign s1_start = head_s1_q[HEAD_WIDTH + TAG_START_BIT];

  // Stage 2 priority pick: the lowest-index matching rule wins.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    any_match = 1'b0;
    win_idx   = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (match_q[r]) begin
        any_match = 1'b1;
        win_idx   = RULE_IDX_WIDTH'(r);
      end
    end
  end

  assign win_rule = rule_q[win_idx];
  assign hit_d    = s1_start & any_match;
  assign miss_d   = s1_start & ~any_match;

  for (genvar f = 0; f < KEY_FIELD_NUM; f++) begin : g_ext
    head_word_sel u_ext_sel (
      .data_i (head_s1_q[HEAD_WIDTH-1:0]),
      .sel_i  (win_rule.ext_sel[f]),
      .word_o (ext_word[f])
    );
  end

  // Stage 2 registers: delayed slices and the decision, which holds until
  // the next start slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_s2_q    <= '0;
      meta_s2_q    <= '0;
      head_shift_q <= '0;
      meta_shift_q <= '0;
      ext_q        <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      head_s2_q <= head_s1_q;
      meta_s2_q <= meta_s1_q;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      if (s1_start) begin
        head_shift_q <= any_match ? win_rule.head_shift : '0;
        meta_shift_q <= any_match ? win_rule.meta_shift : '0;
        ext_q        <= any_match ? ext_word : '0;
      end
    end
  end

  // Hit/miss statistics, saturating, counted together with the pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_d && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_d && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Packet tracking FSM: blocks config writes from a start slice until the
  // tail has left the two-stage pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (in_start) begin
      state_q <= in_tail ? DRAIN : PKT;
      drain_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ready_q <= 1'b1;
        PKT: begin
          if (in_tail) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          drain_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_head      = head_s2_q;
  assign bus.o_meta      = meta_s2_q;
  assign bus.o_headShift = head_shift_q;
  assign bus.o_metaShift = meta_shift_q;
  assign bus.o_extField  = ext_q;
  assign bus.o_hit       = hit_q;
  assign bus.o_miss      = miss_q;
  assign bus.o_cfg_ready = cfg_ready;
  assign bus.o_hitCnt    = hit_cnt_q;
  assign bus.o_missCnt   = miss_cnt_q;

endmodule

// File: tb/tb_head_shift_ctrl.sv
// Self-checking bench for head_shift_ctrl: a packet-level model predicts
// every output each cycle, and directed packets pin key results by hand.
module tb_head_shift_ctrl;
  import head_shift_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  head_shift_ctrl_if bus ();

  head_shift_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  typedef struct {
    bit                          vld;
    bit                          hit;
    logic [HEAD_SHIFT_WIDTH-1:0] hs;
    logic [META_SHIFT_WIDTH-1:0] ms;
    logic [EXT_W-1:0]            ext;
  } dec_t;

  rule_t                       m_tbl [RULE_NUM];
  logic [HEAD_BUS_W-1:0]       m_h1, m_h2;
  logic [META_BUS_W-1:0]       m_m1, m_m2;
  dec_t                        m_d1;
  logic [HEAD_SHIFT_WIDTH-1:0] m_hs;
  logic [META_SHIFT_WIDTH-1:0] m_ms;
  logic [EXT_W-1:0]            m_ext;
  bit                          m_hit, m_miss;
  logic [31:0]                 m_hit_cnt, m_miss_cnt;
  bit                          m_in_pkt;
  int                          m_drain;
  bit                          m_live = 1'b0;

  function automatic logic [15:0] word_of(input logic [HEAD_BUS_W-1:0] h, input int w);
    logic [HEAD_WIDTH-1:0] d;
    d = h[HEAD_WIDTH-1:0];
    return 16'(d >> (HEAD_WIDTH - SHIFT_WIDTH * (w + 1)));
  endfunction

  // Whole decision for a start slice, taken against the table as it stands.
  function automatic dec_t decide(input logic [HEAD_BUS_W-1:0] h);
    dec_t d;
    bit   found;
    d.vld = 1'b1; d.hit = 1'b0; d.hs = '0; d.ms = '0; d.ext = '0;
    found = 1'b0;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (!found && m_tbl[r].valid &&
          (((word_of(h, int'(m_tbl[r].key_sel)) ^ m_tbl[r].value) & m_tbl[r].mask) == 16'h0)) begin
        found = 1'b1;
        d.hit = 1'b1;
        d.hs  = m_tbl[r].head_shift;
        d.ms  = m_tbl[r].meta_shift;
        for (int f = 0; f < KEY_FIELD_NUM; f++)
          d.ext[f*SHIFT_WIDTH +: SHIFT_WIDTH] = word_of(h, int'(m_tbl[r].ext_sel[f]));
      end
    end
    return d;
  endfunction

  // Compare every cycle at the falling edge, then advance the model to the
  // next rising edge using the inputs that are stable for this cycle.
  initial begin : compare_proc
    bit st, tl, exp_rdy;
    forever begin
      @(negedge clk);
      st = bus.i_head[HEAD_WIDTH + TAG_START_BIT];
      tl = bus.i_head[HEAD_WIDTH + TAG_TAIL_BIT];
      exp_rdy = !rst && !st && !m_in_pkt && (m_drain == 0);
      if (m_live) begin
        check("o_head",      bus.o_head,      m_h2);
        check("o_meta",      bus.o_meta,      m_m2);
        check("o_headShift", bus.o_headShift, m_hs);
        check("o_metaShift", bus.o_metaShift, m_ms);
        check("o_extField",  bus.o_extField,  m_ext);
        check("o_hit",       bus.o_hit,       m_hit);
        check("o_miss",      bus.o_miss,      m_miss);
        check("o_cfg_ready", bus.o_cfg_ready, exp_rdy);
        check("o_hitCnt",    bus.o_hitCnt,    m_hit_cnt);
        check("o_missCnt",   bus.o_missCnt,   m_miss_cnt);
      end
      if (rst) begin
        m_live = 1'b1;
        for (int r = 0; r < RULE_NUM; r++) m_tbl[r].valid = 1'b0;
        m_h1 = '0; m_h2 = '0; m_m1 = '0; m_m2 = '0;
        m_d1.vld = 1'b0;
        m_hs = '0; m_ms = '0; m_ext = '0; m_hit = 1'b0; m_miss = 1'b0;
        m_hit_cnt = '0; m_miss_cnt = '0;
        m_in_pkt = 1'b0; m_drain = 0;
      end else if (m_live) begin
        if (m_d1.vld) begin
          m_hit = m_d1.hit; m_miss = !m_d1.hit;
          m_hs = m_d1.hs; m_ms = m_d1.ms; m_ext = m_d1.ext;
          if (m_d1.hit && m_hit_cnt != 32'hFFFF_FFFF) m_hit_cnt++;
          if (!m_d1.hit && m_miss_cnt != 32'hFFFF_FFFF) m_miss_cnt++;
        end else begin
          m_hit = 1'b0; m_miss = 1'b0;
        end
        if (st) m_d1 = decide(bus.i_head);
        else    m_d1.vld = 1'b0;
        m_h2 = m_h1; m_h1 = bus.i_head;
        m_m2 = m_m1; m_m1 = bus.i_meta;
        if (bus.i_cfg_valid && exp_rdy) m_tbl[bus.i_cfg_addr] = rule_t'(bus.i_cfg_data);
        if (st && tl)            begin m_in_pkt = 1'b0; m_drain = 2; end
        else if (st)             begin m_in_pkt = 1'b1; m_drain = 0; end
        else if (m_in_pkt && tl) begin m_in_pkt = 1'b0; m_drain = 2; end
        else if (m_drain > 0)    m_drain--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HEAD_WIDTH-1:0] put_word(input logic [HEAD_WIDTH-1:0] d,
                                                     input int w, input logic [15:0] v);
    logic [HEAD_WIDTH-1:0] r;
    r = d;
    r[HEAD_WIDTH-1-w*SHIFT_WIDTH -: SHIFT_WIDTH] = v;
    return r;
  endfunction

  // Head whose word i holds base+i.
  function automatic logic [HEAD_WIDTH-1:0] mk_head(input logic [15:0] base);
    logic [HEAD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < HEAD_WORDS; i++) r = put_word(r, i, base + 16'(i));
    return r;
  endfunction

  function automatic rule_t mk_rule(input bit v, input int ks, input logic [15:0] val,
                                    input logic [15:0] msk, input int hs, input int ms,
                                    input int e3, input int e2, input int e1, input int e0);
    rule_t r;
    r.valid = v; r.key_sel = 5'(ks); r.value = val; r.mask = msk;
    r.head_shift = 5'(hs); r.meta_shift = 4'(ms);
    r.ext_sel[3] = 5'(e3); r.ext_sel[2] = 5'(e2); r.ext_sel[1] = 5'(e1); r.ext_sel[0] = 5'(e0);
    return r;
  endfunction

  task automatic set_slice(input bit s, input bit t, input logic [HEAD_WIDTH-1:0] d);
    logic [TAG_WIDTH-1:0] tag;
    tag = '0;
    tag[TAG_START_BIT] = s;
    tag[TAG_TAIL_BIT]  = t;
    tag[TAG_VALID_BIT] = 1'b1;
    bus.i_head = {tag, d};
    bus.i_meta = {tag, d[META_WIDTH-1:0] ^ {8{32'h5A5A_0F0F}}};
  endtask

  task automatic slice(input bit s, input bit t, input logic [HEAD_WIDTH-1:0] d);
    set_slice(s, t, d);
    tick();
  endtask

  task automatic idle(input int n);
    bus.i_head = '0;
    bus.i_meta = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Single-slice packet; returns in the cycle its decision is visible.
  task automatic send_single(input logic [HEAD_WIDTH-1:0] d);
    slice(1'b1, 1'b1, d);
    idle(1);
  endtask

  task automatic cfg_write(input int addr, input rule_t r);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_addr  = RULE_IDX_WIDTH'(addr);
    bus.i_cfg_data  = r;
    #1;
    check("cfg_ready_idle", bus.o_cfg_ready, 1'b1);
    tick();
    bus.i_cfg_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [HEAD_WIDTH-1:0] h;
    int n;
    rst = 1'b1;
    bus.i_head = '0; bus.i_meta = '0;
    bus.i_cfg_valid = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_data = '0;
    tick();
    check("rst_hit",   bus.o_hit,       1'b0);
    check("rst_hitcnt", bus.o_hitCnt,   32'd0);
    check("rst_ready", bus.o_cfg_ready, 1'b0);
    check("rst_head",  bus.o_head,      '0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Rule 0 on word6 == 0800, single-slice packet.
    cfg_write(0, mk_rule(1'b1, 6, 16'h0800, 16'hFFFF, 7, 1, 13, 12, 8, 7));
    idle(1);
    h = put_word(mk_head(16'hA000), 6, 16'h0800);
    send_single(h);
    check("t1_hs",     bus.o_headShift, 5'd7);
    check("t1_ms",     bus.o_metaShift, 4'd1);
    check("t1_hit",    bus.o_hit,       1'b1);
    check("t1_ext",    bus.o_extField,  64'hA00D_A00C_A008_A007);
    check("t1_hitcnt", bus.o_hitCnt,    32'd1);
    check("t1_start",  bus.o_head[HEAD_WIDTH + TAG_START_BIT], 1'b1);
    idle(3);

    // Rules 2 and 5 both match; rule 2 must win.
    cfg_write(2, mk_rule(1'b1, 3, 16'hB003, 16'hFFFF, 12, 5, 0, 1, 2, 31));
    cfg_write(5, mk_rule(1'b1, 9, 16'h1234, 16'h0000, 20, 9, 5, 5, 5, 5));
    idle(1);
    send_single(mk_head(16'hB000));
    check("t2_hs",  bus.o_headShift, 5'd12);
    check("t2_ms",  bus.o_metaShift, 4'd5);
    check("t2_ext", bus.o_extField,  64'hB000_B001_B002_B01F);
    idle(3);
    check("t2_hold", bus.o_headShift, 5'd12);

    // Empty the table with valid=0 writes, then a miss.
    cfg_write(0, mk_rule(1'b0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));
    cfg_write(2, mk_rule(1'b0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));
    cfg_write(5, mk_rule(1'b0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));
    idle(1);
    send_single(put_word(mk_head(16'hD000), 6, 16'h0800));
    check("t3_miss",    bus.o_miss,      1'b1);
    check("t3_hs",      bus.o_headShift, 5'd0);
    check("t3_ext",     bus.o_extField,  64'd0);
    check("t3_misscnt", bus.o_missCnt,   32'd1);
    idle(3);

    // Config request held across a 4-slice packet.
    slice(1'b1, 1'b0, mk_head(16'hE000));
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_addr  = RULE_IDX_WIDTH'(1);
    bus.i_cfg_data  = mk_rule(1'b1, 0, 16'hC000, 16'hFF00, 3, 2, 1, 2, 3, 4);
    slice(1'b0, 1'b0, mk_head(16'hE100));
    slice(1'b0, 1'b0, mk_head(16'hE200));
    slice(1'b0, 1'b1, mk_head(16'hE300));
    bus.i_head = '0; bus.i_meta = '0;
    #1;
    n = 0;
    while (!bus.o_cfg_ready && n < 10) begin
      n++;
      tick();
    end
    check("t4_drain_cycles", n, 2);
    tick();
    bus.i_cfg_valid = 1'b0;
    idle(1);
    send_single(mk_head(16'hC000));
    check("t4_hs",  bus.o_headShift, 5'd3);
    check("t4_ext", bus.o_extField,  64'hC001_C002_C003_C004);
    idle(3);

    // Config write in the same cycle as a start bit is refused.
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_addr  = RULE_IDX_WIDTH'(1);
    bus.i_cfg_data  = mk_rule(1'b1, 0, 16'hC000, 16'hFF00, 25, 15, 0, 0, 0, 0);
    set_slice(1'b1, 1'b1, mk_head(16'hC000));
    #1;
    check("t5_ready_start", bus.o_cfg_ready, 1'b0);
    tick();
    bus.i_cfg_valid = 1'b0;
    idle(1);
    check("t5_old_hs", bus.o_headShift, 5'd3);
    idle(3);
    send_single(mk_head(16'hC055));
    check("t5_still_old", bus.o_headShift, 5'd3);
    idle(3);

    // Reset in the middle of a packet.
    slice(1'b1, 1'b0, mk_head(16'hC000));
    rst = 1'b1;
    slice(1'b0, 1'b0, mk_head(16'hC100));
    rst = 1'b0;
    set_slice(1'b0, 1'b0, mk_head(16'hC200));
    #1;
    check("t6_ready_after_rst", bus.o_cfg_ready, 1'b1);
    tick();
    slice(1'b0, 1'b1, mk_head(16'hC300));
    idle(3);
    check("t6_hitcnt",  bus.o_hitCnt,    32'd0);
    check("t6_misscnt", bus.o_missCnt,   32'd0);
    check("t6_hs",      bus.o_headShift, 5'd0);
    send_single(mk_head(16'hC000));
    check("t6_miss",     bus.o_miss,    1'b1);
    check("t6_misscnt1", bus.o_missCnt, 32'd1);
    idle(3);

    // Miss counter saturation.
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    m_miss_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.miss_cnt_q;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send_single(mk_head(16'h7000 + 16'(i)));
      idle(3);
    end
    check("t7_sat", bus.o_missCnt, 32'hFFFF_FFFF);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/head_shift_ctrl.md
Name: head_shift_ctrl

Overview:
- Per-stage controller for the head/meta shift datapath of one parser stage.
- Classifies each packet from its first head slice against a programmable rule table.
- Drives headShift, metaShift and the extracted key fields to the downstream shift stage, aligned with the delayed start slice.
- Owns the table's config-write handshake, which is blocked while a packet is in flight, plus hit/miss statistics.

Parameters:
- HEAD_WIDTH, 512, head slice data width in bits
- TAG_WIDTH, 8, tag width appended above data (start/valid/tail/shift bit positions come from the shared package)
- META_WIDTH, 256, metadata width in bits
- SHIFT_WIDTH, 16, bits per shift unit / field word
- HEAD_SHIFT_WIDTH, 5, shift amount width; HEAD_WIDTH/SHIFT_WIDTH = 32 word positions
- META_SHIFT_WIDTH, 4, meta shift width
- KEY_FIELD_NUM, 4, extracted fields per packet
- RULE_NUM, 8, rule table entries

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_head  in  HEAD_WIDTH+TAG_WIDTH  incoming head slice plus tag
- i_meta  in  META_WIDTH+TAG_WIDTH  incoming meta slice plus tag
- o_head  out  HEAD_WIDTH+TAG_WIDTH  i_head delayed 2 cycles
- o_meta  out  META_WIDTH+TAG_WIDTH  i_meta delayed 2 cycles
- o_headShift  out  HEAD_SHIFT_WIDTH  selected head shift
- o_metaShift  out  META_SHIFT_WIDTH  selected meta shift
- o_extField  out  KEY_FIELD_NUM*SHIFT_WIDTH  extracted fields; field 0 in the LSBs
- o_hit / o_miss  out  1 each  one-cycle pulses, coincident with the output start slice
- i_cfg_valid  in  1  config write request
- i_cfg_addr  in  $clog2(RULE_NUM)  rule index
- i_cfg_data  in  RULE_W  packed rule_t
- o_cfg_ready  out  1  write accepted when valid&ready
- o_hitCnt / o_missCnt  out  32 each  saturating counters

Behaviour:
- Reset, synchronous, active-high (i_rst=1 at posedge):
  - All rule valid bits cleared; FSM to IDLE.
  - Pipeline tags zeroed; o_head/o_meta data zeroed; shift/ext outputs 0.
  - o_hit/o_miss 0, counters 0, o_cfg_ready 0 during reset.
  - Reset mid-packet abandons the packet. Slices after reset deassertion are ignored until the next start bit.
- Rule fields (rule_t): valid(1), key_sel(5), value(16), mask(16), headShift(HEAD_SHIFT_WIDTH), metaShift(META_SHIFT_WIDTH), ext_sel[KEY_FIELD_NUM](5 each).
- Word index w = SHIFT_WIDTH-bit word at bits [HEAD_WIDTH-1-w*SHIFT_WIDTH -: SHIFT_WIDTH]; word 0 is MSB-most.
- Stage 1, on the i_head cycle with the start bit:
  - Per rule: match = valid & ((word[key_sel] & mask) == (value & mask)).
  - Register the match vector and the head data.
- Stage 2:
  - Lowest-index matching rule wins.
  - o_headShift, o_metaShift, o_extField[i] = word[ext_sel_i] from the start slice; o_hit=1.
  - No match: o_headShift=0, o_metaShift=0, o_extField=0, o_miss=1.
- Latency: the output start slice and its decision appear together, exactly 2 cycles after the input start slice.
- Shift/ext outputs hold their value until the next decision. Non-start slices pass through unmodified with 2-cycle delay.
- FSM:
  - IDLE: o_cfg_ready=1. Start bit → PKT. A cfg write accepted in the same cycle as a start bit is not allowed: start wins, ready forced 0.
  - PKT: ready=0. Tail bit on input → DRAIN. A slice carrying both start and tail → DRAIN directly from IDLE.
  - DRAIN: ready=0 for 2 cycles (pipeline empty) → IDLE. A new start bit during DRAIN → PKT.
- Config writes take effect for the next start slice after acceptance; the table is never modified between a packet's stage 1 and stage 2.
- An accepted write with valid=0 disables the entry.
- Counters increment on o_hit/o_miss and saturate at 32'hFFFF_FFFF.

Decomposition:
- Shared package (parser pkg) holds:
  - rule_t struct and RULE_W.
  - TAG_START_BIT, TAG_VALID_BIT, TAG_TAIL_BIT, TAG_SHIFT_BIT.
  - Width constants shared with the shift stage.
  - FSM state enum {IDLE, PKT, DRAIN}.
- One natural sub-module: head_word_sel, a combinational word-index mux returning word[sel]. Instanced once for the key select per rule and once per extracted field.

Test Plan:
- Rule0 = {key_sel=6, value=16'h0800, mask=16'hFFFF, headShift=7, metaShift=1, ext_sel={13,12,8,7}}; single-slice packet with word6=0800 → 2 cycles later: o_headShift=7, o_metaShift=1, o_hit=1, o_extField words correct, hitCnt=1.
- Rules 2 and 5 both match (mask 16'h0000 on rule 5) → rule 2 fields selected; no match (table empty) → zero outputs, o_miss=1, missCnt=1.
- i_cfg_valid held from the slice after start through a 4-slice packet → o_cfg_ready=0 through the tail and 2 DRAIN cycles, then write accepted; next packet uses the new rule.
- Cfg write and start bit asserted in the same IDLE cycle → write not accepted; packet classified with the old table.
- i_rst pulsed while in PKT → outputs and counters 0, state IDLE; the rest of the old packet produces no o_hit/o_miss; the next start classifies normally with the table empty.
- missCnt preloaded near max (force 32'hFFFF_FFFE) then 3 misses → saturates at 32'hFFFF_FFFF.
